// File: rtl/seg_collram_sweep.sv
// seg_collram_sweep
//   Bit-per-address collision store shared by SRC_N collision sources.
//   The CPU can clear single bits, clear the summary flag and read one bit.
//   A hardware sweep FSM clears the whole store on request.
//
// Parameters
//   ADDR_W : address width; the store holds 2**ADDR_W bits
//   SRC_N  : number of collision sources (1..4)
//
// Ports
//   clk            video clock
//   RESET          synchronous reset, active-high
//   cpu_ad         CPU bit address
//   cpu_wr_coll    clear store[cpu_ad]
//   cpu_wr_collclr clear the summary flag and the event counter
//   cpu_rd_coll    {coll_sm, 6'b111111, coll_rd}; the read has 1 clk latency
//   coll_ad        packed source addresses; source i = [i*ADDR_W +: ADDR_W]
//   coll           per-source set strobes
//   clr_start      one-cycle pulse that starts a sweep
//   clr_busy       high while a sweep is running
//   cpu_rd_cnt     collision event counter (zero unless COLL_COUNT_EN)
//
// Build option
//   COLL_COUNT_EN : when defined, adds a saturating 8-bit event counter
module seg_collram_sweep #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SRC_N  = 2
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [ADDR_W-1:0]       cpu_ad,
  input  logic                    cpu_wr_coll,
  input  logic                    cpu_wr_collclr,
  output logic [7:0]              cpu_rd_coll,
  input  logic [SRC_N*ADDR_W-1:0] coll_ad,
  input  logic [SRC_N-1:0]        coll,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic [7:0]              cpu_rd_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_AD = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [DEPTH-1:0]  mem, mem_next;
  logic              coll_rd;
  logic              coll_sm;

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        if (ptr == LAST_AD) begin
          state_next = IDLE;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_busy = (state == SWEEP);

  // Store update: later assignments override earlier ones, so the order
  // below is lowest priority first (CPU clear, sweep clear, source set).
  always_comb begin
    mem_next = mem;
    if (cpu_wr_coll) begin
      mem_next[cpu_ad] = 1'b0;
    end
    if (state == SWEEP) begin
      mem_next[ptr] = 1'b0;
    end
    for (int unsigned i = 0; i < SRC_N; i++) begin
      if (coll[i]) begin
        mem_next[coll_ad[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      mem     <= '0;
      coll_rd <= 1'b0;
      coll_sm <= 1'b0;
    end else begin
      mem     <= mem_next;
      coll_rd <= mem[cpu_ad];
      if (cpu_wr_collclr) begin
        coll_sm <= 1'b0;
      end else if (|coll) begin
        coll_sm <= 1'b1;
      end
    end
  end

  assign cpu_rd_coll = {coll_sm, 6'b111111, coll_rd};

`ifdef COLL_COUNT_EN
  logic [7:0] cnt;
  logic [2:0] pop;
  logic [8:0] sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < SRC_N; i++) begin
      pop = pop + {2'b00, coll[i]};
    end
    sum = {1'b0, cnt} + {6'b000000, pop};
  end

  always_ff @(posedge clk) begin
    if (RESET || cpu_wr_collclr) begin
      cnt <= '0;
    end else if (sum[8]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[7:0];
    end
  end

  assign cpu_rd_cnt = cnt;
`else
  assign cpu_rd_cnt = 8'h00;
`endif

endmodule

// File: doc/seg_collram_sweep.md
Name: seg_collram_sweep

Overview:
- Parametrised successor to the fixed-size mixer/sprite collision RAMs in the System 1/2 video path.
- One bit-per-address collision store with configurable depth and SRC_N independent collision sources.
- CPU interface: bit clear, summary clear, read.
- Adds a hardware sweep FSM that clears the whole store on request, e.g. at VBLANK, so software loops are not needed.

Parameters:
- ADDR_W, 10, address width; store depth = 2**ADDR_W bits (6 gives the mixer variant, 10 the sprite variant).
- SRC_N, 2, number of collision sources, 1..4.

Ports:
- clk  in  1  video clock (VCLKx8 domain).
- RESET  in  1  synchronous reset, active-high.
- cpu_ad  in  ADDR_W  CPU bit address.
- cpu_wr_coll  in  1  CPU write strobe: clear bit cpu_ad.
- cpu_wr_collclr  in  1  CPU write strobe: clear summary flag (and event counter).
- cpu_rd_coll  out  8  {coll_sm, 6'b111111, coll_rd}.
- coll_ad  in  SRC_N*ADDR_W  packed collision addresses; source i = bits [i*ADDR_W +: ADDR_W].
- coll  in  SRC_N  per-source collision set strobes.
- clr_start  in  1  one-cycle pulse: start a hardware sweep.
- clr_busy  out  1  high while sweep is active.
- cpu_rd_cnt  out  8  collision event count (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high, on port RESET, sampled on the rising edge of clk.
- Reset: all store bits 0; coll_sm=0; coll_rd=0; FSM IDLE; clr_busy=0; sweep pointer 0; cpu_rd_cnt=0.
- Reset mid-sweep aborts the sweep; the store is fully cleared by reset itself.
- Store write priority, per address per cycle: RESET > collision set > sweep clear > CPU bit clear.
- All SRC_N sources may set distinct or identical addresses in the same cycle; every addressed bit becomes 1.
- CPU clear and collision set on the same address in the same cycle: bit ends 1. This is a deliberate change from the legacy clear-wins rule, so no hit is lost.
- Read: coll_rd <= store[cpu_ad] every cycle, so latency is 1 clk. It shows the pre-write value when a write to the same address occurs in that cycle.
- Summary coll_sm is set when any coll bit is 1.
- cpu_wr_collclr in the same cycle as a set: coll_sm ends 0 (clear wins, matches legacy software expectation).
- FSM IDLE:
  - clr_start=1 -> SWEEP; pointer <= 0; clr_busy <= 1 on the next edge.
- FSM SWEEP:
  - Each cycle clears store[pointer], then pointer+1.
  - When pointer = 2**ADDR_W-1, clears that address and -> IDLE; clr_busy <= 0.
  - Sweep lasts exactly 2**ADDR_W cycles (64 for ADDR_W=6).
  - clr_start during SWEEP is ignored; no restart.
  - A collision set at an address the sweep has already passed stays 1.
  - A set at the address being cleared in that cycle wins (bit=1).
  - CPU reads and writes remain functional during SWEEP.
- The sweep never touches coll_sm.
- Pointer is ADDR_W bits wide; there is no wrap past the last address.

Optional Feature:
- Macro COLL_COUNT_EN.
- Defined:
  - 8-bit event counter increments by popcount(coll) each cycle, saturating at 255.
  - Cleared by cpu_wr_collclr; clear wins over an increment in the same cycle.
  - Driven on cpu_rd_cnt, registered.
- Undefined: no counter logic; cpu_rd_cnt tied to 8'h00.

Test Plan:
- Reset, then read addresses 0, 5 and 2**ADDR_W-1 -> cpu_rd_coll = 8'h7E each, one cycle after the address is applied.
- coll=2'b01, coll_ad src0=10'd37 for 1 clk, then read 37 -> 8'hFF; read 38 -> 8'hFE; cpu_wr_collclr pulse then read 37 -> 8'h7F.
- Same cycle: coll=2'b11 with both sources at 10'd100, plus cpu_wr_coll at 100 -> read 100 gives bit0=1. Repeat with cpu_wr_collclr -> coll_sm=0.
- Set addresses 0, 512, 1023; pulse clr_start:
  - clr_busy high for exactly 1024 cycles.
  - Second clr_start at cycle 10 is ignored.
  - After busy falls all three read bit0=0; coll_sm is unchanged at 1.
- During sweep, set address 3 at sweep cycle 500 and address 900 at the cycle pointer=900 -> both read 1 after the sweep ends.
- COLL_COUNT_EN:
  - 200 cycles of coll=2'b11 -> cpu_rd_cnt=255 (saturated).
  - cpu_wr_collclr -> 0.
  - Without the macro, cpu_rd_cnt stays 0 throughout.
